// File: rtl/avr_io_intc.sv
// avr_io_intc: up to 8-line interrupt controller for avr_core.
// Latches edge/level sources, masks them with IER and GIE, and picks a vector
// by fixed or round-robin priority. The iflag/ivect outputs are registered.
// The next-state values (including same-cycle writes and iack) feed the
// selector, so a register write or an acknowledge takes effect at the same edge.
module avr_io_intc #(
    parameter int N_IRQ      = 4,
    parameter int INTR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  io_re,
    input  logic                  io_we,
    input  logic [1:0]            io_a,
    input  logic [7:0]            io_do,
    output logic [7:0]            io_di,
    input  logic [N_IRQ-1:0]      irq,
    input  logic                  iack,
    output logic                  iflag,
    output logic [INTR_WIDTH-1:0] ivect
);

    localparam logic [INTR_WIDTH-1:0] PTR_RST = INTR_WIDTH'(N_IRQ - 1);

    logic [N_IRQ-1:0]      ier, imode, edge_pend, irq_q;
    logic                  gie, rr;
    logic [INTR_WIDTH-1:0] rr_ptr;

    logic [N_IRQ-1:0]      ier_nx, imode_nx, edge_pend_nx, pend_nx, act;
    logic [N_IRQ-1:0]      ipr_clr, ack_vec, pend_cur;
    logic                  gie_nx, rr_nx, ack_ok;
    logic [INTR_WIDTH-1:0] rr_ptr_nx, rr_start, sel;
    logic [2*N_IRQ-1:0]    act_rot;
    logic [7:0]            ictrl_rd;

    // Register writes as they will look after this edge.
    always_comb begin
        ier_nx   = ier;
        imode_nx = imode;
        gie_nx   = gie;
        rr_nx    = rr;
        ipr_clr  = '0;
        if (io_we) begin
            case (io_a)
                2'd0:    ier_nx   = io_do[N_IRQ-1:0];
                2'd1:    ipr_clr  = io_do[N_IRQ-1:0];
                2'd2:    imode_nx = io_do[N_IRQ-1:0];
                default: begin
                    gie_nx = io_do[0];
                    rr_nx  = io_do[1];
                end
            endcase
        end
    end

    // Acknowledge only counts while a vector is actually being presented.
    always_comb begin
        ack_ok  = iack & iflag;
        ack_vec = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (ack_ok && (int'(ivect) == i)) ack_vec[i] = 1'b1;
        end
        rr_ptr_nx = ack_ok ? ivect : rr_ptr;
    end

    // Pending state after this edge; a new edge beats a same-cycle clear,
    // and level-mode lines never hold a latched edge.
    always_comb begin
        edge_pend_nx = imode_nx & ((irq & ~irq_q) | (edge_pend & ~(ipr_clr | ack_vec)));
        pend_nx      = (imode_nx & edge_pend_nx) | (~imode_nx & irq);
        act          = pend_nx & ier_nx;
    end

    // Vector selection: lowest index, or rotated search starting after rr_ptr.
    always_comb begin
        int  tmp_idx;
        logic found;
        tmp_idx  = 0;
        found    = 1'b0;
        sel      = '0;
        rr_start = (int'(rr_ptr_nx) >= N_IRQ - 1) ? '0 : rr_ptr_nx + INTR_WIDTH'(1);
        act_rot  = {act, act} >> rr_start;
        if (rr_nx) begin
            for (int i = 0; i < N_IRQ; i++) begin
                if (!found && act_rot[i]) begin
                    tmp_idx = int'(rr_start) + i;
                    if (tmp_idx >= N_IRQ) tmp_idx = tmp_idx - N_IRQ;
                    sel   = INTR_WIDTH'(tmp_idx);
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < N_IRQ; i++) begin
                if (!found && act[i]) begin
                    sel   = INTR_WIDTH'(i);
                    found = 1'b1;
                end
            end
        end
    end

    // State register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ier       <= '0;
            imode     <= '0;
            edge_pend <= '0;
            irq_q     <= '0;
            gie       <= 1'b0;
            rr        <= 1'b0;
            rr_ptr    <= PTR_RST;
            iflag     <= 1'b0;
            ivect     <= '0;
        end else begin
            ier       <= ier_nx;
            imode     <= imode_nx;
            edge_pend <= edge_pend_nx;
            irq_q     <= irq;
            gie       <= gie_nx;
            rr        <= rr_nx;
            rr_ptr    <= rr_ptr_nx;
            iflag     <= gie_nx & (|act);
            ivect     <= sel;
        end
    end

    // Read mux; idles at zero so it can be OR-ed onto the shared bus.
    always_comb begin
        pend_cur    = (imode & edge_pend) | (~imode & irq_q);
        ictrl_rd    = 8'h00;
        ictrl_rd[0] = gie;
        ictrl_rd[1] = rr;
        ictrl_rd[7] = iflag;
        for (int i = 0; i < INTR_WIDTH; i++) begin
            if (i < 3) ictrl_rd[4+i] = ivect[i];
        end
        io_di = 8'h00;
        if (io_re) begin
            case (io_a)
                2'd0:    io_di = 8'(ier);
                2'd1:    io_di = 8'(pend_cur);
                2'd2:    io_di = 8'(imode);
                default: io_di = ictrl_rd;
            endcase
        end
    end

endmodule

// File: doc/avr_io_intc.md
# avr_io_intc

Parametrised interrupt controller that replaces the fixed 4-line combinational priority encoder in front of `avr_core`. It latches up to 8 interrupt sources (per-line edge or level mode), applies an enable mask and global enable, selects a vector by fixed or round-robin priority, and presents registered `iflag`/`ivect` to the core. The core acknowledges each taken interrupt with `iack`. Software configures the block through four AVR I/O registers on the shared I/O bus.

## Interface
- `N_IRQ`, 4: number of interrupt lines, legal range 1..8.
- `INTR_WIDTH`, 2: vector width. Must satisfy 2^INTR_WIDTH >= N_IRQ. Matches core parameter `intr_width`.
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `io_re` input 1: I/O read strobe, already qualified by the block select.
- `io_we` input 1: I/O write strobe, already qualified by the block select.
- `io_a` input 2: register select.
- `io_do` input 8: write data from the core.
- `io_di` output 8: read data to the core. Driven 8'h00 when `io_re`=0 so it can be OR-combined on the bus.
- `irq` input N_IRQ: raw interrupt lines, synchronous to `clk`.
- `iack` input 1: one-cycle pulse from the core when it vectors on the current `ivect`.
- `iflag` output 1: registered, an enabled interrupt is pending.
- `ivect` output INTR_WIDTH: registered, index of the selected line.

## Operation
- Registers, addressed by `io_a`:
  - 0 IER: enable mask, R/W.
  - 1 IPR: pending. Reads return the effective pending state. Writing 1 to a bit clears a latched edge bit.
  - 2 IMODE: per line, 1 = rising-edge, 0 = level. R/W.
  - 3 ICTRL: bit0 GIE (R/W), bit1 RR (R/W; 1 = round-robin), bits[6:4] `ivect` (RO), bit7 `iflag` (RO).
- Register bits at index >= N_IRQ read 0 and ignore writes. ICTRL bits 2, 3 and any `ivect` bits above INTR_WIDTH read 0.
- Sampling: `irq_q <= irq` every cycle.
- Edge lines:
  - `edge_pend[i]` is set when `irq[i] & ~irq_q[i]`.
  - It is cleared by an IPR write-1 or by `iack` while `ivect`==i.
  - If set and clear occur in the same cycle, set wins.
- Level lines:
  - Effective pending = `irq_q[i]`.
  - IPR writes and `iack` have no effect.
  - `edge_pend[i]` is cleared while the line is in level mode.
- Active vector: `act = pend_next & IER_next`, where `_next` denotes the post-edge values, including writes and `iack` in that same cycle.
- Selection:
  - RR=0: the lowest set index in `act` wins.
  - RR=1: search starts at `(rr_ptr+1) mod N_IRQ` and wraps.
  - `rr_ptr` loads `ivect` on each `iack`.
- Outputs:
  - `iflag <= GIE_next & |act`.
  - `ivect <= selected index`, or 0 if `act`==0.
- An `iack` while `iflag`=0 is ignored, with no clear and no pointer update.
- Reset values:
  - IER, IMODE, ICTRL, `edge_pend`, `irq_q`: 0.
  - `rr_ptr` = N_IRQ-1, so the first round-robin search starts at line 0.
  - `iflag` = 0, `ivect` = 0, `io_di` = 0.
- Reset asserted mid-operation discards all pending state in the same edge. A line held high through reset in level mode reasserts one edge after reset release once IER/GIE are set again.

## Timing
- IRQ latency: a line that becomes active before edge E yields `iflag`/`ivect` valid after E (1 cycle), in both modes.
- `iack` sampled at edge E clears the edge-pending bit and updates `iflag`/`ivect` at that same E. There is no stale cycle. Another pending line appears immediately with its vector.
- IER, IMODE, ICTRL and IPR writes at edge E affect `iflag` from E.
- `io_di` is combinational from the current register state and valid in the same cycle as `io_re`.
- Switching a line level→edge while it is high creates no edge, because `irq_q` is already high.

## Test plan
- Reset, then GIE=1, IER=8'h0F, IMODE=0, pulse nothing → `iflag`=0, `ivect`=0. IPR read=8'h00. ICTRL read=8'h01.
- Level mode: drive `irq`=4'b1010 → `iflag`=1, `ivect`=1 one cycle later. Drop `irq[1]` → `ivect`=3 next cycle. `iack` leaves `irq[3]` pending.
- Edge mode, IMODE=8'h0F: pulse `irq[2]` for 1 cycle → IPR=8'h04, `iflag` holds after the pulse ends. `iack` → `iflag`=0 at the same edge. A new rising edge coinciding with IPR write 8'h04 → the bit stays set.
- Round-robin, RR=1, edge lines 0, 1 and 3 pending: three successive `iack`s → `ivect` sequence 0, 1, 3. Then re-pend 0 and 3 → next `ivect`=0, because the search starts after 3 and wraps.
- Masking: GIE=0 with IPR=8'h01 → `iflag`=0, pending retained. Set GIE=1 → `iflag`=1 the next cycle. IER bit cleared → `iflag` drops the next cycle.
- Assert `rst` with pending lines and `iflag`=1 → all registers 0 and `iflag`=0 after one edge. `io_re`=0 → `io_di`=8'h00 throughout.
